// File: rtl/maple_in_pkg.sv
// maple_pkg: shared FSM encoding, status bit positions and receiver defaults
package maple_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_START = 3'd1, ST_PH_A = 3'd2,
                          ST_PH_B = 3'd3, ST_END = 3'd4, ST_DONE = 3'd5;
   localparam int START_PULSES = 4;
   localparam int DEF_TIMEOUT = 255;
   localparam int SB_BUSY = 0, SB_NEMPTY = 1, SB_FULL = 2, SB_OVF = 3,
                  SB_FRAMING = 4, SB_TIMEOUT = 5, SB_CRC = 6, SB_DONE = 7;
endpackage

// File: rtl/maple_in_if.sv
// maple_in_if: host register-port strobes and write data
interface maple_in_if;
   logic cs_ctrl, cs_data, we;
   logic [7:0] regdata_in;
   modport master(output cs_ctrl, cs_data, we, regdata_in);
   modport slave(input cs_ctrl, cs_data, we, regdata_in);
endinterface

// File: rtl/maple_in_fifo.sv
// maple_in_fifo: synchronous byte FIFO, push accepted when full only alongside a pop
module maple_in_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic wr_ok, rd_ok;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign dout = mem[rp[AW-1:0]];
   assign wr_ok = push && (!full || pop);
   assign rd_ok = pop && !empty;
   always_ff @(posedge clk)
      if (wr_ok) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_ok) wp <= wp + (AW+1)'(1);
         if (rd_ok) rp <= rp + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/maple_in.sv
// maple_in: Maple bus frame receiver with host register port; MAPLE_IN_CRC_EN adds XOR frame check
module maple_in
   import maple_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   maple_in_if.slave  host,
   inout  wire  [7:0] regdata_out,
   input  logic       pin1,
   input  logic       pin5,
   input  logic       oe,
   output logic       frame_irq
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [2:0] p1, p5, state, pulses, nbits;
   logic [5:0] sh;
   logic [TW-1:0] idle_cnt;
   logic [7:0] byte_in, fifo_out, status, rd_val;
   logic pa, f_done, f_to, f_fr, f_ovf, crc_ok, full, empty, pop, clr, kill, live;
   logic fall1, rise1, fall5, rise5, edge_any, expired, start, shift, push, done_set, bad_start, bad_end;
   logic unused;
   assign unused = ^host.regdata_in[7:2];
   // p*[1] is the synchronized line, p*[2] its previous value
   always_ff @(posedge clk) begin
      if (rst) begin
         p1 <= '1;
         p5 <= '1;
      end else begin
         p1 <= {p1[1:0], pin1};
         p5 <= {p5[1:0], pin5};
      end
   end
   assign fall1 = p1[2] && !p1[1];
   assign rise1 = !p1[2] && p1[1];
   assign fall5 = p5[2] && !p5[1];
   assign rise5 = !p5[2] && p5[1];
   assign edge_any = (p1[2] ^ p1[1]) || (p5[2] ^ p5[1]);
   assign clr = host.cs_ctrl && host.we && host.regdata_in[0];
   assign kill = oe || (host.cs_ctrl && host.we && host.regdata_in[1]);
   assign expired = state != ST_IDLE && !edge_any && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign live = !kill && !expired;
   assign start = live && state == ST_IDLE && fall1 && p5[1];
   assign bad_start = live && state == ST_START && rise1 && pulses != 3'(START_PULSES);
   assign bad_end = live && state == ST_PH_B && fall1 && nbits != 3'd0;
   assign shift = live && state == ST_PH_B && fall5 && !fall1;
   assign push = shift && nbits == 3'd6;
   assign done_set = live && state == ST_END && rise5;
   assign byte_in = {sh, pa, p1[1]};
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         {pulses, nbits, sh, pa, idle_cnt} <= '0;
         {f_done, f_to, f_fr, f_ovf, frame_irq} <= '0;
      end else begin
         frame_irq <= expired || done_set;
         idle_cnt <= (state == ST_IDLE || edge_any) ? '0 : idle_cnt + TW'(1);
         if (!live) state <= ST_IDLE;
         else case (state)
            ST_IDLE:  if (start) state <= ST_START;
            ST_START: if (rise1) state <= bad_start ? ST_IDLE : ST_PH_A;
            ST_PH_A:  if (fall1) state <= ST_PH_B;
            ST_PH_B:  if (fall1) state <= ST_END; else if (fall5) state <= ST_PH_A;
            ST_END:   if (rise5) state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
         if (start) {pulses, nbits} <= '0;
         else if (state == ST_START && fall5 && !p1[1] && pulses != 3'd7) pulses <= pulses + 3'd1;
         if (state == ST_PH_A && fall1) pa <= p5[1];
         // bit pairs are committed only once the PH_B half arrives, so an end pattern drops its PH_A bit
         if (shift) begin
            sh <= {sh[3:0], pa, p1[1]};
            nbits <= nbits + 3'd2;
         end
         if (start || clr) {f_done, f_to, f_fr, f_ovf} <= '0;
         else begin
            if (done_set) f_done <= 1'b1;
            if (expired) f_to <= 1'b1;
            if (bad_start || bad_end) f_fr <= 1'b1;
            if (push && full && !pop) f_ovf <= 1'b1;
         end
      end
   end
`ifdef MAPLE_IN_CRC_EN
   logic [7:0] xr;
   always_ff @(posedge clk) begin
      if (rst || start) xr <= '0;
      else if (push) xr <= xr ^ byte_in;
      if (rst || start || clr) crc_ok <= 1'b0;
      else if (done_set) crc_ok <= xr == 8'h00;
   end
`else
   assign crc_ok = 1'b0;
`endif
   maple_in_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk), .rst(rst), .flush(clr), .push(push), .pop(pop),
      .din(byte_in), .dout(fifo_out), .full(full), .empty(empty)
   );
   always_comb begin
      status = '0;
      status[SB_DONE] = f_done;
      status[SB_CRC] = crc_ok;
      status[SB_TIMEOUT] = f_to;
      status[SB_FRAMING] = f_fr;
      status[SB_OVF] = f_ovf;
      status[SB_FULL] = full;
      status[SB_NEMPTY] = !empty;
      status[SB_BUSY] = state != ST_IDLE;
   end
   assign pop = host.cs_data && !host.we;
   assign rd_val = host.cs_ctrl ? status : (empty ? 8'h00 : fifo_out);
   assign regdata_out = ((host.cs_ctrl || host.cs_data) && !host.we) ? rd_val : 'z;
endmodule

// File: tb/tb_maple_in.sv
// tb_maple_in: randomized Maple frames checked against a byte-level reference model
module tb_maple_in;
   typedef logic [7:0] bq_t [$];
   logic clk = 0, rst = 1, pin1 = 1, pin5 = 1, oe = 0, ph = 0;
   logic frame_irq;
   wire [7:0] regdata_out;
   int n_chk = 0, n_fail = 0, irq_cnt = 0, irq_base = 0;
`ifdef MAPLE_IN_CRC_EN
   localparam bit CRC_ON = 1;
`else
   localparam bit CRC_ON = 0;
`endif
   maple_in_if host();
   maple_in dut (
      .clk(clk), .rst(rst), .host(host), .regdata_out(regdata_out),
      .pin1(pin1), .pin5(pin5), .oe(oe), .frame_irq(frame_irq)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (frame_irq) irq_cnt++;
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [7:0] st(input bit done, crc, to, fr, ovf, input int occ, input bit busy);
      return {done, crc, to, fr, ovf, occ == 8, occ != 0, busy};
   endfunction
   task automatic rd(input logic ctrl, output logic [7:0] v);
      host.cs_ctrl = ctrl;
      host.cs_data = !ctrl;
      host.we = 0;
      #1 v = regdata_out;
      tick(1);
      host.cs_ctrl = 0;
      host.cs_data = 0;
   endtask
   task automatic wr(input logic [7:0] v);
      host.cs_ctrl = 1;
      host.we = 1;
      host.regdata_in = v;
      tick(1);
      host.cs_ctrl = 0;
      host.we = 0;
   endtask
   task automatic pins(input logic a, input logic b);
      pin1 = a;
      pin5 = b;
      tick(4);
   endtask
   task automatic start_pat(input int n);
      pins(1, 1);
      pins(0, 1);
      repeat (n) begin
         pins(0, 0);
         pins(0, 1);
      end
      pins(1, 1);
      ph = 0;
   endtask
   // phase A: data on pin5, pin1 falls; phase B: data on pin1, pin5 falls
   task automatic send_bit(input logic b);
      if (!ph) begin
         pins(1, pin5);
         pins(1, b);
         pins(0, b);
      end else begin
         pins(0, 1);
         pins(b, 1);
         pins(b, 0);
      end
      ph = !ph;
   endtask
   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask
   task automatic end_pat();
      pins(1, 1);
      pins(0, 1);
      pins(1, 1);
      pins(0, 1);
      pins(0, 0);
      pins(0, 1);
      pins(1, 1);
   endtask
   task automatic drain(input string tag, input bq_t q);
      logic [7:0] v;
      foreach (q[i]) begin
         rd(0, v);
         chk({tag, " data"}, v, q[i]);
      end
      rd(0, v);
      chk({tag, " drained"}, v, 8'h00);
   endtask
   task automatic full_frame(input string tag, input bq_t bytes);
      bq_t q;
      logic [7:0] x, v;
      x = 0;
      foreach (bytes[i]) begin
         x ^= bytes[i];
         if (q.size() < 8) q.push_back(bytes[i]);
      end
      irq_base = irq_cnt;
      start_pat(4);
      foreach (bytes[i]) send_byte(bytes[i]);
      end_pat();
      rd(1, v);
      chk({tag, " status"}, v, st(1, CRC_ON && x == 0, 0, 0, bytes.size() > 8, q.size(), 0));
      chk({tag, " irq"}, 8'(irq_cnt - irq_base), 8'd1);
      drain(tag, q);
   endtask
   initial begin
      bq_t q;
      logic [7:0] v, b, c;
      logic [31:0] w;
      int n;
      host.cs_ctrl = 0;
      host.cs_data = 0;
      host.we = 0;
      host.regdata_in = 0;
      tick(3);
      rst = 0;
      tick(1);
      rd(1, v);
      chk("reset status", v, 8'h00);
      chk("reset irq", {7'b0, frame_irq}, 8'h00);
      rd(0, v);
      chk("reset empty read", v, 8'h00);
      w = 32'h01200021;
      for (int i = 3; i >= 0; i--) q.push_back(w[i*8 +: 8]);
      full_frame("basic", q);
      start_pat(3);
      rd(1, v);
      chk("short start status", v, st(0, 0, 0, 1, 0, 0, 0));
      rd(0, v);
      chk("short start empty", v, 8'h00);
      irq_base = irq_cnt;
      start_pat(4);
      b = 8'($urandom);
      for (int i = 7; i > 2; i--) send_bit(b[i]);
      tick(300);
      rd(1, v);
      chk("timeout status", v, st(0, 0, 1, 0, 0, 0, 0));
      chk("timeout irq", 8'(irq_cnt - irq_base), 8'd1);
      rd(0, v);
      chk("timeout empty", v, 8'h00);
      pins(1, 1);
      q.delete();
      for (int i = 0; i < 9; i++) q.push_back(8'(i * 37 + 5));
      full_frame("overflow", q);
      for (int k = 0; k < 4; k++) begin
         q.delete();
         n = $urandom_range(1, 10);
         repeat (n) q.push_back(8'($urandom));
         full_frame("random", q);
      end
      irq_base = irq_cnt;
      start_pat(4);
      b = 8'($urandom);
      send_byte(b);
      for (int i = 7; i > 3; i--) send_bit(b[i]);
      oe = 1;
      pins(1, 1);
      oe = 0;
      tick(2);
      rd(1, v);
      chk("oe status", v, st(0, 0, 0, 0, 0, 1, 0));
      chk("oe irq", 8'(irq_cnt - irq_base), 8'd0);
      wr(8'h01);
      rd(1, v);
      chk("clear status", v, 8'h00);
      rd(0, v);
      chk("clear empty", v, 8'h00);
      start_pat(4);
      b = 8'($urandom);
      c = 8'($urandom);
      send_byte(b);
      for (int i = 0; i < 4; i++) send_bit(c[i]);
      end_pat();
      rd(1, v);
      chk("short frame status", v, st(1, CRC_ON && b == 8'h00, 0, 1, 0, 1, 0));
      q.delete();
      q.push_back(b);
      drain("short frame", q);
      start_pat(4);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom));
      rd(1, v);
      chk("busy status", v, st(0, 0, 0, 0, 0, 0, 1));
      wr(8'h02);
      rd(1, v);
      chk("forced idle status", v, 8'h00);
      pins(1, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
